// File: rtl/pll_pkg.sv
// Shared types and constants for the PLL lock supervisor.
// Supervisor state encoding, 12 MHz -> 60 MHz divider defaults, width helper.
package pll_pkg;

    typedef enum logic [2:0] {
        IDLE,
        RESET_PLL,
        WAIT_LOCK,
        QUALIFY,
        RUN,
        FAULT
    } pll_state_e;

    // 12 MHz reference -> 60 MHz core clock
    localparam logic [3:0] DEF_DIVR   = 4'd0;
    localparam logic [6:0] DEF_DIVF   = 7'd79;
    localparam logic [2:0] DEF_DIVQ   = 3'd4;
    localparam logic [2:0] DEF_FILTER = 3'd1;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/ice_pll_core.sv
// iCE40 SB_PLL40_CORE wrapper, SIMPLE feedback, bypass tied off.
// Ports: ref_clk in, resetb in (active low), lock out, pll_out out.
module ice_pll_core #(
    parameter logic [3:0] DIVR         = 4'd0,
    parameter logic [6:0] DIVF         = 7'd79,
    parameter logic [2:0] DIVQ         = 3'd4,
    parameter logic [2:0] FILTER_RANGE = 3'd1
) (
    input  logic ref_clk,
    input  logic resetb,
    output logic lock,
    output logic pll_out
);

`ifdef SYNTHESIS
    SB_PLL40_CORE #(
        .FEEDBACK_PATH ("SIMPLE"),
        .PLLOUT_SELECT ("GENCLK"),
        .DIVR          (DIVR),
        .DIVF          (DIVF),
        .DIVQ          (DIVQ),
        .FILTER_RANGE  (FILTER_RANGE)
    ) u_pll (
        .REFERENCECLK    (ref_clk),
        .PLLOUTCORE      (pll_out),
        .PLLOUTGLOBAL    (),
        .EXTFEEDBACK     (1'b0),
        .DYNAMICDELAY    (8'h00),
        .LOCK            (lock),
        .BYPASS          (1'b0),
        .RESETB          (resetb),
        .LATCHINPUTVALUE (1'b0),
        .SDI             (1'b0),
        .SDO             (),
        .SCLK            (1'b0)
    );
`else
    // Behavioural stand-in: LOCK rises a fixed number of reference
    // cycles after RESETB rises; the output clock is the reference.
    localparam logic [3:0] DLY_LAST = 4'd10;

    logic [3:0]  dly_cnt;
    logic [16:0] unused_cfg;

    assign unused_cfg = {DIVR, DIVF, DIVQ, FILTER_RANGE};

    always_ff @(posedge ref_clk or negedge resetb) begin
        if (!resetb) begin
            dly_cnt <= '0;
        end else if (dly_cnt != DLY_LAST) begin
            dly_cnt <= dly_cnt + 4'd1;
        end
    end

    assign lock    = (dly_cnt == DLY_LAST);
    assign pll_out = ref_clk;
`endif

endmodule

// File: rtl/pll_lock_supervisor.sv
// iCE40 PLL plus lock supervisor on the reference clock: PLL reset, lock
// qualification, retry/fault handling and the chip-wide reset request.
// Ports: clock_in, reset (async, high), enable, clear_fault in;
//        clock_out, ready, rst_out, fault, lock_lost, retry_count out.
module pll_lock_supervisor
    import pll_pkg::*;
#(
    parameter logic [3:0] DIVR           = DEF_DIVR,
    parameter logic [6:0] DIVF           = DEF_DIVF,
    parameter logic [2:0] DIVQ           = DEF_DIVQ,
    parameter logic [2:0] FILTER_RANGE   = DEF_FILTER,
    parameter int         RESET_CYCLES   = 16,
    parameter int         LOCK_CYCLES    = 1024,
    parameter int         TIMEOUT_CYCLES = 65536,
    parameter int         MAX_RETRIES    = 3,
    localparam int        RETRY_W        = $clog2(MAX_RETRIES + 1)
) (
    input  logic               clock_in,
    input  logic               reset,
    input  logic               enable,
    input  logic               clear_fault,
    output logic               clock_out,
    output logic               ready,
    output logic               rst_out,
    output logic               fault,
    output logic               lock_lost,
    output logic [RETRY_W-1:0] retry_count
);

    localparam int CNT_W =
        $clog2(max_int(TIMEOUT_CYCLES, LOCK_CYCLES) + 1);

    localparam logic [CNT_W-1:0] RST_LAST = CNT_W'(RESET_CYCLES - 1);
    localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
    localparam logic [CNT_W-1:0] QLF_LAST = CNT_W'(LOCK_CYCLES - 1);
    localparam logic [RETRY_W-1:0] RETRY_MAX = RETRY_W'(MAX_RETRIES);

    pll_state_e         state, state_nxt;
    logic [CNT_W-1:0]   cnt, cnt_nxt;
    logic [RETRY_W-1:0] retry_nxt, retry_inc;
    logic               lost_nxt;
    logic [1:0]         lock_sync;
    logic               lock_s;
    logic               pll_lock;
    logic               pll_resetb;

    ice_pll_core #(
        .DIVR         (DIVR),
        .DIVF         (DIVF),
        .DIVQ         (DIVQ),
        .FILTER_RANGE (FILTER_RANGE)
    ) u_core (
        .ref_clk (clock_in),
        .resetb  (pll_resetb),
        .lock    (pll_lock),
        .pll_out (clock_out)
    );

    // Decoded straight from the state register so an async reset
    // pulls the PLL into reset without waiting for a clock edge.
    assign pll_resetb = (state == WAIT_LOCK) || (state == QUALIFY)
                     || (state == RUN);

    assign lock_s    = lock_sync[1];
    assign retry_inc = retry_count + RETRY_W'(1);

    always_comb begin
        state_nxt = state;
        retry_nxt = retry_count;
        lost_nxt  = lock_lost;
        if (clear_fault) lost_nxt = 1'b0;
        unique case (state)
            IDLE: begin
                if (enable) state_nxt = RESET_PLL;
            end
            RESET_PLL: begin
                if (cnt == RST_LAST) state_nxt = WAIT_LOCK;
            end
            WAIT_LOCK: begin
                if (lock_s) begin
                    state_nxt = QUALIFY;
                end else if (cnt == TMO_LAST) begin
                    retry_nxt = retry_inc;
                    state_nxt = (retry_inc == RETRY_MAX) ? FAULT : RESET_PLL;
                end
            end
            QUALIFY: begin
                if (!lock_s) begin
                    state_nxt = WAIT_LOCK;
                end else if (cnt == QLF_LAST) begin
                    state_nxt = RUN;
                    retry_nxt = '0;
                end
            end
            RUN: begin
                if (!lock_s) begin
                    lost_nxt  = 1'b1;
                    state_nxt = RESET_PLL;
                end
            end
            FAULT: begin
                if (clear_fault) begin
                    state_nxt = IDLE;
                    retry_nxt = '0;
                end
            end
            default: state_nxt = IDLE;
        endcase
        // Disable wins over any in-flight transition; the retry tally is kept.
        if (!enable && state != FAULT) begin
            state_nxt = IDLE;
            retry_nxt = retry_count;
        end
        // One shared counter, restarted on every state entry.
        cnt_nxt = cnt;
        if (state_nxt != state) begin
            cnt_nxt = '0;
        end else if (state == RESET_PLL || state == WAIT_LOCK
                  || state == QUALIFY) begin
            cnt_nxt = cnt + CNT_W'(1);
        end
    end

    always_ff @(posedge clock_in or posedge reset) begin
        if (reset) begin
            state       <= IDLE;
            cnt         <= '0;
            retry_count <= '0;
            lock_lost   <= 1'b0;
            lock_sync   <= '0;
            ready       <= 1'b0;
            rst_out     <= 1'b1;
            fault       <= 1'b0;
        end else begin
            state       <= state_nxt;
            cnt         <= cnt_nxt;
            retry_count <= retry_nxt;
            lock_lost   <= lost_nxt;
            lock_sync   <= {lock_sync[0], pll_lock};
            ready       <= (state_nxt == RUN);
            rst_out     <= (state_nxt != RUN);
            fault       <= (state_nxt == FAULT);
        end
    end

endmodule

// File: tb/tb_pll_lock_supervisor.sv
// Testbench for pll_lock_supervisor: directed scenarios plus a cycle model.
// Ports: none.
module tb_pll_lock_supervisor;

    localparam int RC  = 4;
    localparam int LC  = 8;
    localparam int TC  = 32;
    localparam int MR  = 2;
    localparam int DLY = 10;

    localparam int P_IDLE  = 0;
    localparam int P_RST   = 1;
    localparam int P_WAIT  = 2;
    localparam int P_QUAL  = 3;
    localparam int P_RUN   = 4;
    localparam int P_FAULT = 5;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       enable = 1'b0;
    logic       clear_fault = 1'b0;
    logic       clock_out, ready, rst_out, fault, lock_lost;
    logic [1:0] retry_count;

    int asserts = 0;
    int fails   = 0;
    int n;

    // spec-level model state
    int m_ph = P_IDLE;
    int m_el = 0;
    int m_rc = 0;
    int m_lcnt = 0;
    bit m_ll = 1'b0;
    bit m_s1 = 1'b0;
    bit m_s2 = 1'b0;
    bit m_frc = 1'b0;

    logic [6:0] got, want;

    always #5 clk = ~clk;

    pll_lock_supervisor #(
        .RESET_CYCLES   (RC),
        .LOCK_CYCLES    (LC),
        .TIMEOUT_CYCLES (TC),
        .MAX_RETRIES    (MR)
    ) dut (
        .clock_in    (clk),
        .reset       (rst),
        .enable      (enable),
        .clear_fault (clear_fault),
        .clock_out   (clock_out),
        .ready       (ready),
        .rst_out     (rst_out),
        .fault       (fault),
        .lock_lost   (lock_lost),
        .retry_count (retry_count)
    );

    function automatic bit pll_on(input int ph);
        return ph == P_WAIT || ph == P_QUAL || ph == P_RUN;
    endfunction

    task automatic model_step();
        bit raw, ls;
        int nx;
        raw = m_frc ? 1'b0 : (m_lcnt >= DLY);
        ls  = m_s2;
        m_s2 = m_s1;
        m_s1 = raw;
        if (pll_on(m_ph) && m_lcnt < DLY) m_lcnt++;
        nx = m_ph;
        if (clear_fault) m_ll = 1'b0;
        if (m_ph == P_FAULT) begin
            if (clear_fault) begin
                nx = P_IDLE;
                m_rc = 0;
            end
        end else begin
            if (m_ph == P_RUN && !ls) m_ll = 1'b1;
            if (!enable) begin
                nx = P_IDLE;
            end else if (m_ph == P_IDLE) begin
                nx = P_RST;
            end else if (m_ph == P_RST) begin
                if (m_el == RC - 1) nx = P_WAIT;
            end else if (m_ph == P_WAIT) begin
                if (ls) begin
                    nx = P_QUAL;
                end else if (m_el == TC - 1) begin
                    m_rc++;
                    nx = (m_rc == MR) ? P_FAULT : P_RST;
                end
            end else if (m_ph == P_QUAL) begin
                if (!ls) begin
                    nx = P_WAIT;
                end else if (m_el == LC - 1) begin
                    nx = P_RUN;
                    m_rc = 0;
                end
            end else if (m_ph == P_RUN && !ls) begin
                nx = P_RST;
            end
        end
        m_el = (nx != m_ph) ? 0 : m_el + 1;
        m_ph = nx;
        if (!pll_on(m_ph)) m_lcnt = 0;
    endtask

    initial forever begin
        @(posedge clk or posedge rst);
        if (rst) begin
            m_ph = P_IDLE;
            m_el = 0;
            m_rc = 0;
            m_lcnt = 0;
            m_ll = 1'b0;
            m_s1 = 1'b0;
            m_s2 = 1'b0;
        end else begin
            model_step();
        end
    end

    initial forever begin
        @(negedge clk);
        got  = {ready, rst_out, fault, lock_lost, retry_count,
                dut.pll_resetb};
        want = {m_ph == P_RUN, m_ph != P_RUN, m_ph == P_FAULT, m_ll,
                2'(m_rc), pll_on(m_ph)};
        asserts++;
        if (got !== want) begin
            fails++;
            $display("FAIL model t=%0t rdy/rst/flt/lost/retry2/rb got=%b want=%b",
                     $time, got, want);
        end
    end

    task automatic chk(input string nm, input int act, input int exp);
        asserts++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
        end
    endtask

    function automatic logic probe(input int k);
        case (k)
            0:       return ready;
            1:       return dut.pll_resetb;
            2:       return fault;
            default: return retry_count != 2'd0;
        endcase
    endfunction

    task automatic step(input int c);
        repeat (c) begin
            @(posedge clk);
            @(negedge clk);
        end
    endtask

    task automatic wait_for(input int k, input logic v, input int lim,
                            output int cyc);
        cyc = 0;
        do begin
            @(posedge clk);
            @(negedge clk);
            cyc++;
        end while (probe(k) !== v && cyc < lim);
    endtask

    task automatic lock_off();
        force dut.pll_lock = 1'b0;
        m_frc = 1'b1;
    endtask

    task automatic lock_on();
        release dut.pll_lock;
        m_frc = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog expired at t=%0t", $time);
        $fatal(1);
    end

    initial begin
        repeat (2) @(negedge clk);
        chk("reset rst_out", int'(rst_out), 1);
        chk("reset ready", int'(ready), 0);
        chk("clock_out follows ref", int'(clock_out), int'(clk));
        rst = 1'b0;
        step(2);

        // 1: nominal bring-up
        enable = 1'b1;
        wait_for(1, 1'b1, 40, n);
        chk("nominal resetb rise cycle", n, RC + 1);
        wait_for(0, 1'b1, 60, n);
        chk("nominal ready after resetb", n, 21);
        chk("nominal rst_out", int'(rst_out), 0);
        chk("nominal retry", int'(retry_count), 0);
        enable = 1'b0;
        step(1);
        chk("disable in RUN ready", int'(ready), 0);
        chk("disable in RUN rst_out", int'(rst_out), 1);
        step(2);

        // 2: glitch while qualifying
        enable = 1'b1;
        step(22);
        lock_off();
        step(3);
        chk("glitch not ready", int'(ready), 0);
        lock_on();
        wait_for(0, 1'b1, 30, n);
        chk("glitch requalify cycles", n, 11);
        chk("glitch retry", int'(retry_count), 0);

        // 3: timeouts into FAULT
        enable = 1'b0;
        step(2);
        lock_off();
        enable = 1'b1;
        wait_for(3, 1'b1, 60, n);
        chk("first timeout cycle", n, RC + TC + 1);
        wait_for(2, 1'b1, 60, n);
        chk("second timeout to fault", n, RC + TC);
        chk("fault resetb", int'(dut.pll_resetb), 0);
        chk("fault retry", int'(retry_count), 2);
        enable = 1'b0;
        step(3);
        chk("fault holds without enable", int'(fault), 1);
        clear_fault = 1'b1;
        step(1);
        clear_fault = 1'b0;
        chk("clear fault", int'(fault), 0);
        chk("clear fault retry", int'(retry_count), 0);
        lock_on();

        // 4: retry cleared on RUN, then lock loss and relock
        lock_off();
        enable = 1'b1;
        wait_for(3, 1'b1, 60, n);
        chk("retry before run", n, RC + TC + 1);
        lock_on();
        wait_for(0, 1'b1, 60, n);
        chk("relock after timeout", n, 25);
        chk("run clears retry", int'(retry_count), 0);
        lock_off();
        wait_for(0, 1'b0, 10, n);
        chk("lock loss latency", n, 3);
        chk("lock loss sticky", int'(lock_lost), 1);
        chk("lock loss rst_out", int'(rst_out), 1);
        lock_on();
        wait_for(1, 1'b1, 20, n);
        chk("lock loss resetb low", n, RC);
        wait_for(0, 1'b1, 40, n);
        chk("lock loss rerun", n, 21);
        chk("lock_lost kept in RUN", int'(lock_lost), 1);

        // 5: clear outside FAULT, simultaneous drop + disable, disable in WAIT
        clear_fault = 1'b1;
        step(1);
        clear_fault = 1'b0;
        chk("clear lock_lost only", int'(lock_lost), 0);
        chk("clear keeps ready", int'(ready), 1);
        lock_off();
        step(2);
        enable = 1'b0;
        step(1);
        chk("drop+disable ready", int'(ready), 0);
        chk("drop+disable lost", int'(lock_lost), 1);
        chk("drop+disable resetb", int'(dut.pll_resetb), 0);
        lock_on();
        enable = 1'b1;
        wait_for(1, 1'b1, 20, n);
        chk("to wait_lock", n, RC + 1);
        enable = 1'b0;
        step(1);
        chk("disable in wait resetb", int'(dut.pll_resetb), 0);
        enable = 1'b1;
        wait_for(1, 1'b1, 20, n);
        chk("restart at reset_pll", n, RC + 1);

        // 6: async reset mid-qualify
        enable = 1'b0;
        step(2);
        enable = 1'b1;
        step(20);
        chk("pre-reset resetb", int'(dut.pll_resetb), 1);
        #2;
        rst = 1'b1;
        #1;
        chk("async ready", int'(ready), 0);
        chk("async rst_out", int'(rst_out), 1);
        chk("async fault", int'(fault), 0);
        chk("async lock_lost", int'(lock_lost), 0);
        chk("async retry", int'(retry_count), 0);
        chk("async resetb", int'(dut.pll_resetb), 0);
        step(2);
        rst = 1'b0;
        step(3);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 asserts, fails);
        $finish;
    end

endmodule
